// File: rtl/mips_mc_ctrl.sv
// ----------------------------------------------------------------------------
// mips_mc_ctrl
//
// Multi-cycle control unit for the MIPS CPU. It sequences one shared datapath
// through fetch, decode, execute, memory and write-back. Instruction fetch and
// data access share a single memory port that uses a req/ack handshake.
//
// Parameters
//   MEM_TIMEOUT   cycles to wait for mem_ack before flagging bus_err (1..255)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   opcode        IR[31:26]
//   funct         IR[5:0]
//   instr_zero    IR == 0 (nop)
//   alu_zero      ALU result == 0
//   mem_ack       memory completed the current request
//   pc_we         PC write enable
//   ir_we         IR write enable
//   reg_we        register-file write enable
//   mem_req       memory request
//   mem_we        memory write, qualified by mem_req
//   iord          memory address source: 0 = PC, 1 = ALUOut
//   alu_op        0 add, 1 sub, 2 or, 3 lui
//   alu_src_a     0 = PC, 1 = A register
//   alu_src_b     0 = B, 1 = 4, 2 = ext imm, 3 = imm << 2
//   ext_op        1 = sign-extend, 0 = zero-extend
//   reg_dst       0 = rt, 1 = rd, 2 = $31
//   wd_sel        0 = ALUOut, 1 = MDR, 2 = PC
//   pc_src        0 = ALU, 1 = ALUOut, 2 = jump target, 3 = A register
//   state         current FSM state (debug)
//   illegal       sticky: unsupported instruction decoded
//   bus_err       sticky: memory handshake timed out
//
// Optional feature (macro MC_CTRL_PERF_EN)
//   cyc_cnt       cycles spent outside HALT
//   ret_cnt       retired instructions (entries into FETCH)
// ----------------------------------------------------------------------------
module mips_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        instr_zero,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        bus_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WB = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_WB_ALU = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    // Last wait-count value before the timeout fires.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Instruction classification from the latched IR fields
    // ------------------------------------------------------------------------
    logic is_rtype;
    logic is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);

    // ------------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------------
    logic [3:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;

    logic in_mem_state;
    logic mem_wait;
    logic mem_timeout;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);
    assign mem_wait     = in_mem_state && !mem_ack;
    assign mem_timeout  = mem_wait && (wait_q == TMO_LAST);

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instr_zero)                  state_d = S_FETCH;
                else if (is_addu || is_subu)     state_d = S_EXEC_R;
                else if (is_ori || is_lui)       state_d = S_EXEC_I;
                else if (is_lw || is_sw)         state_d = S_ADDR;
                else if (is_beq)                 state_d = S_BRANCH;
                else if (is_j || is_jal || is_jr) state_d = S_JUMP;
                else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_WB_ALU: state_d = S_FETCH;
            S_ADDR: begin
                state_d = is_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ack) state_d = S_MEM_WB;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ack) state_d = S_FETCH;
            end
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase

        // The wait counter only survives while the FSM sits in a memory
        // state without an ack; any state change leaves it at zero.
        if (mem_timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end else if (mem_wait) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

    // ------------------------------------------------------------------------
    // Datapath control (Moore on state_q / IR fields, except the FETCH
    // enables that wait for mem_ack and pc_we in BRANCH)
    // ------------------------------------------------------------------------
    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        ext_op    = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        pc_src    = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                // The reset term keeps a stray mem_ack from writing the PC or
                // IR while the core is held in reset.
                ir_we     = mem_ack && reset;
                pc_we     = mem_ack && reset;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = is_subu ? ALU_SUB : ALU_ADD;
                reg_dst   = 2'd1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = is_lui ? ALU_LUI : ALU_OR;
            end
            S_WB_ALU: begin
                reg_we  = 1'b1;
                reg_dst = is_rtype ? 2'd1 : 2'd0;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_we = 1'b1;
                wd_sel = 2'd1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_we     = alu_zero;
                pc_src    = 2'd1;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = is_jr ? 2'd3 : 2'd2;
                // PC already holds PC+4, which is the link value for jal.
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                end
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (state_q != S_HALT) cyc_cnt_d = cyc_cnt_q + 32'd1;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) ret_cnt_d = ret_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule
